// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor:
// FSM state encoding, operation encodings and a counter-width helper.
package serial_addsub_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Operation select values for the op input
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Bits needed for a counter that must reach the value w without wrapping
   function automatic int cnt_bits(input int w);
      return (w < 2) ? 1 : $clog2(w + 1);
   endfunction

endpackage : serial_addsub_pkg

// File: rtl/serial_addsub_fa_cell.sv
// One-bit full adder used as the single arithmetic element of the
// bit-serial datapath.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule : fa_cell

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. Operands are captured on an accepted start,
// one bit pair is processed per SHIFT cycle through a single full adder,
// and the result/flags are committed with a one-cycle done pulse.
// Subtraction is a + ~b + 1 (inverted operand, carry seeded with 1).
// Optional feature: define SERIAL_ADDSUB_OVF_EN to build the two's-complement
// overflow flag; without it overflow is tied to 0 and its logic is absent.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int CNT_W = cnt_bits(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               cout_q, cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic               ovf_pend_q, ovf_pend_d;
   logic               ovf_q, ovf_d;
`endif

   logic fa_s;
   logic fa_co;

   // Single full adder working on the current operand LSBs
   fa_cell u_fa (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // Next-state and datapath update for the serial controller
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      result_d = result_q;
      cout_d   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_pend_d = ovf_pend_q;
      ovf_d      = ovf_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b ^ {WIDTH{op}};
               carry_d = (op == OP_SUB);
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = fa_co;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
`ifdef SERIAL_ADDSUB_OVF_EN
               // carry into the MSB is carry_q on this final step
               ovf_pend_d = carry_q ^ fa_co;
`endif
               state_d = DONE;
            end
         end

         DONE: begin
            // Commit the finished word and flags together with the pulse
            result_d = sum_sh_q;
            cout_d   = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_d    = ovf_pend_q;
`endif
            done_d   = 1'b1;
            state_d  = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SHIFT);
   end

   // State and registered outputs; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf_pend_q <= 1'b0;
         ovf_q      <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         cout_q   <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf_pend_q <= ovf_pend_d;
         ovf_q      <= ovf_d;
`endif
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign cout   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=4): directed vector table,
// multi-cycle corner sequences and random operations against an
// arithmetic reference model.
module tb_serial_addsub;

   localparam int W = 4;
   localparam int LAT = W + 1;
`ifdef SERIAL_ADDSUB_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         op = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;

   int n_checks = 0;
   int n_fail   = 0;

   serial_addsub #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views
   task automatic model(input logic op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        output logic [W-1:0] r, output logic c, output logic v);
      int full, sa, sb, exact;
      full  = op_v ? (int'(a_v) + (1 << W) - int'(b_v)) : (int'(a_v) + int'(b_v));
      r     = W'(full % (1 << W));
      c     = (full >= (1 << W));
      sa    = (a_v >= (1 << (W - 1))) ? int'(a_v) - (1 << W) : int'(a_v);
      sb    = (b_v >= (1 << (W - 1))) ? int'(b_v) - (1 << W) : int'(b_v);
      exact = op_v ? sa - sb : sa + sb;
      v     = OVF_ON && ((exact > (1 << (W - 1)) - 1) || (exact < -(1 << (W - 1))));
   endtask

   // Launch one operation and wait (bounded) for done; returns latency in edges
   task automatic run_op(input logic op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                         output int lat);
      op = op_v; a = a_v; b = b_v; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // Scramble operands after capture; they must not affect the result
      op = 1'($urandom); a = W'($urandom); b = W'($urandom);
      chk("busy_after_start", int'(busy), 1);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
         chk("busy_during_op", int'(busy), int'(k < W));
      end
   endtask

   initial begin
      int lat;
      int pulses;
      int first_done;
      logic [W-1:0] er;
      logic ec, ev;

      vecs[0] = '{op: 1'b0, a: 4'd3, b: 4'd4, res: 4'd7,  cout: 1'b0, ovf: 1'b0};
      vecs[1] = '{op: 1'b0, a: 4'd9, b: 4'd8, res: 4'd1,  cout: 1'b1, ovf: 1'b1};
      vecs[2] = '{op: 1'b1, a: 4'd5, b: 4'd3, res: 4'd2,  cout: 1'b1, ovf: 1'b0};
      vecs[3] = '{op: 1'b1, a: 4'd3, b: 4'd5, res: 4'd14, cout: 1'b0, ovf: 1'b0};
      vecs[4] = '{op: 1'b1, a: 4'd7, b: 4'd8, res: 4'd15, cout: 1'b0, ovf: 1'b1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_result", int'(result), 0);
      chk("reset_cout", int'(cout), 0);
      chk("reset_overflow", int'(overflow), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors, back-to-back
      for (int i = 0; i < 5; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         $display("vec %0d: op=%0d a=%0d b=%0d -> result=%0d cout=%0d ovf=%0d lat=%0d",
                  i, vecs[i].op, vecs[i].a, vecs[i].b, result, cout, overflow, lat);
         chk("vec_latency", lat, LAT);
         chk("vec_result", int'(result), int'(vecs[i].res));
         chk("vec_cout", int'(cout), int'(vecs[i].cout));
         chk("vec_overflow", int'(overflow), int'(vecs[i].ovf & OVF_ON));
      end
      @(posedge clk); #1;
      chk("done_single_cycle", int'(done), 0);
      chk("result_held", int'(result), 15);

      // start pulsed during SHIFT must be ignored
      op = 1'b0; a = 4'd3; b = 4'd4; start = 1'b1;
      @(posedge clk); #1;
      a = 4'd1; b = 4'd1;
      pulses = 0; first_done = -1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (k == 3) start = 1'b0;
         if (done) begin
            pulses++;
            if (first_done < 0) first_done = k;
         end
      end
      $display("ignore_start: result=%0d pulses=%0d first_done=%0d", result, pulses, first_done);
      chk("ignore_start_pulses", pulses, 1);
      chk("ignore_start_latency", first_done, LAT);
      chk("ignore_start_result", int'(result), 7);

      // Reset on the 2nd SHIFT cycle, asserted together with start
      op = 1'b0; a = 4'd6; b = 4'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_result", int'(result), 0);
      chk("midreset_done", int'(done), 0);
      chk("midreset_cout", int'(cout), 0);
      rst_n = 1'b1; start = 1'b0;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      chk("midreset_no_done", pulses, 0);
      chk("midreset_idle_busy", int'(busy), 0);
      run_op(1'b0, 4'd2, 4'd2, lat);
      $display("after_reset: 2+2 -> result=%0d lat=%0d", result, lat);
      chk("after_reset_latency", lat, LAT);
      chk("after_reset_result", int'(result), 4);

      // Random operations against the reference model
      for (int i = 0; i < 40; i++) begin
         logic         rop;
         logic [W-1:0] ra, rb;
         rop = 1'($urandom);
         ra  = W'($urandom);
         rb  = W'($urandom);
         model(rop, ra, rb, er, ec, ev);
         run_op(rop, ra, rb, lat);
         $display("rand %0d: op=%0d a=%0d b=%0d -> result=%0d cout=%0d ovf=%0d (exp %0d %0d %0d)",
                  i, rop, ra, rb, result, cout, overflow, er, ec, ev);
         chk("rand_latency", lat, LAT);
         chk("rand_result", int'(result), int'(er));
         chk("rand_cout", int'(cout), int'(ec));
         chk("rand_overflow", int'(overflow), int'(ev));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_serial_addsub

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, operand/result bit width (WIDTH >= 2).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port start  input  1  request to begin an operation, sampled in IDLE only.
REQ-005 SHALL provide port op  input  1  0 = add (a+b), 1 = subtract (a-b), captured with start.
REQ-006 SHALL provide ports a, b  input  WIDTH  operands, captured with start.
REQ-007 SHALL provide port busy  output  1  high while bits are being processed.
REQ-008 SHALL provide port done  output  1  one-cycle pulse marking a valid result.
REQ-009 SHALL provide port result  output  WIDTH  sum/difference, held until the next accepted start.
REQ-010 SHALL provide port cout  output  1  final carry; for subtract, 1 = no borrow (a >= b unsigned).
REQ-011 SHALL provide port overflow  output  1  two's-complement overflow flag.

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 SHALL load a and (b XOR {WIDTH{op}}) into shift registers, set carry=op, clear bit counter, go to SHIFT.
REQ-014 Each SHIFT cycle SHALL full-add the operand LSBs with carry, shift the sum bit into the result MSB, shift operands right, update carry, increment counter.
REQ-015 After exactly WIDTH SHIFT cycles the FSM SHALL enter DONE; done=1 there for one cycle, then return to IDLE.
REQ-016 Latency: done SHALL assert on the (WIDTH+1)th rising edge after the edge sampling start.
REQ-017 busy SHALL be 1 in SHIFT only; 0 in IDLE and DONE.
REQ-018 start SHALL be ignored in SHIFT and DONE; operands changing after capture SHALL not affect the result.
REQ-019 result, cout, overflow SHALL be valid from DONE onward and hold until the next accepted start.
REQ-020 Arithmetic SHALL wrap modulo 2^WIDTH; carry out of the MSB goes to cout only.
REQ-021 A start in the IDLE cycle right after DONE SHALL be accepted (back-to-back operation).

Reset
REQ-022 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, result=0, cout=0, overflow=0, counter=0.
REQ-023 Reset mid-SHIFT SHALL abort the operation with no done pulse.
REQ-024 Reset SHALL dominate start in the same cycle.

Configuration
REQ-025 Macro SERIAL_ADDSUB_OVF_EN defined: overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB of the final step.
REQ-026 Macro SERIAL_ADDSUB_OVF_EN undefined: overflow SHALL be constant 0 and its logic omitted.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE/SHIFT/DONE) and op encodings (OP_ADD=0, OP_SUB=1).
REQ-028 The per-bit adder SHALL be a sub-module fa_cell (inputs a, b, ci; outputs s, co), instantiated once.

Verification (WIDTH=4, SERIAL_ADDSUB_OVF_EN defined)
REQ-029 op=0, a=3, b=4 -> done 5 cycles after start; result=7, cout=0, overflow=0.
REQ-030 op=0, a=9, b=8 -> result=1, cout=1, overflow=1.
REQ-031 op=1, a=5, b=3 -> result=2, cout=1, overflow=0; op=1, a=3, b=5 -> result=14, cout=0, overflow=0.
REQ-032 op=1, a=7, b=8 -> result=15, cout=0, overflow=1.
REQ-033 start pulsed with a=1,b=1 during SHIFT of 3+4 -> ignored; result=7, single done pulse.
REQ-034 rst_n=0 on 2nd SHIFT cycle -> next cycle busy=0, result=0, no done; a subsequent 2+2 yields result=4.
